// File: rtl/pc_ras_if.sv
// Control/status bundle between the decoder and the fetch-stage program counter.
interface pc_ras_if #(
  parameter int PC_W  = 9,
  parameter int CNT_W = 3
);
  logic            Halt;
  logic            jump_en;
  logic            branch_en;
  logic            rel_en;
  logic            call_en;
  logic            ret_en;
  logic            EQ;
  logic [PC_W-1:0] Target;
  logic [PC_W-1:0] Offset;
  logic [PC_W-1:0] PC;
  logic [CNT_W-1:0] ras_count;
  logic            ras_ovf;
  logic            ras_unf;

  modport master (
    output Halt, jump_en, branch_en, rel_en, call_en, ret_en, EQ, Target, Offset,
    input  PC, ras_count, ras_ovf, ras_unf
  );
  modport slave (
    input  Halt, jump_en, branch_en, rel_en, call_en, ret_en, EQ, Target, Offset,
    output PC, ras_count, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with jump/branch (absolute or PC-relative),
// call/return through a return-address stack, and sticky stack-error flags.
module pc_ras_unit #(
  parameter int PC_W      = 9,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC  = 0,
  parameter bit COND_DLY  = 1'b1
) (
  input  logic CLK,
  input  logic Init,
  pc_ras_if.slave bus
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_ras [RAS_DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf, r_unf, r_eq_q;

  logic             w_flag, w_full, w_empty;
  logic [PC_W-1:0]  w_pc_inc, w_tgt;
  logic [IDX_W-1:0] w_push_idx, w_top_idx;

  assign w_flag     = COND_DLY ? r_eq_q : bus.EQ;
  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_tgt      = bus.rel_en ? (r_pc + bus.Offset) : bus.Target;
  assign w_full     = (r_cnt == CNT_W'(RAS_DEPTH));
  assign w_empty    = (r_cnt == '0);
  // Indices are only used when not full (push) / not empty (pop), so they stay in range.
  assign w_push_idx = IDX_W'(r_cnt);
  assign w_top_idx  = IDX_W'(r_cnt - CNT_W'(1));

  always_ff @(posedge CLK) begin
    if (Init) begin
      r_pc   <= PC_W'(RESET_PC);
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_eq_q <= 1'b0;
    end else begin
      // The flag stage keeps sampling during Halt so the condition stays current.
      r_eq_q <= bus.EQ;
      if (!bus.Halt) begin
        if (bus.ret_en) begin
          if (!w_empty) begin
            r_pc  <= r_ras[w_top_idx];
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_unf <= 1'b1;
            r_pc  <= w_pc_inc;
          end
        end else if (bus.call_en) begin
          if (!w_full) begin
            r_ras[w_push_idx] <= w_pc_inc;
            r_cnt             <= r_cnt + CNT_W'(1);
          end else begin
            r_ovf <= 1'b1;
          end
          r_pc <= bus.Target;
        end else if (bus.jump_en || (bus.branch_en && w_flag)) begin
          r_pc <= w_tgt;
        end else begin
          r_pc <= w_pc_inc;
        end
      end
    end
  end

  assign bus.PC        = r_pc;
  assign bus.ras_count = r_cnt;
  assign bus.ras_ovf   = r_ovf;
  assign bus.ras_unf   = r_unf;
endmodule
